// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: holds every domain in reset, then releases
// domains one at a time in index order, waiting for each domain's ack (or a timeout).
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 6,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   I_CLK,
  input  logic                   I_ASYNC_RESET_N,
  input  logic                   I_SW_RESET,
  input  logic [NUM_DOMAINS-1:0] I_DOMAIN_ACK,
  output logic [NUM_DOMAINS-1:0] O_DOMAIN_RESET,
  output logic                   O_READY,
  output logic                   O_BUSY,
  output logic [NUM_DOMAINS-1:0] O_TIMEOUT_ERR
);

  localparam int                IDX_W     = $clog2(NUM_DOMAINS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]        ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RELEASE  = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic [NUM_DOMAINS-1:0] domain_reset_reg, domain_reset_next;
  logic [NUM_DOMAINS-1:0] timeout_err_reg, timeout_err_next;

  logic       set_all;
  logic       release_one;
  logic       timeout_one;
  logic       clear_err;
  logic       ack_sel;
  logic [7:0] cnt_inc;

  assign ack_sel = I_DOMAIN_ACK[idx_reg];
  // Saturating increment: the counter never wraps back into a matching range.
  assign cnt_inc = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_N) begin
    if (!I_ASYNC_RESET_N) begin
      state_reg        <= HOLD;
      idx_reg          <= '0;
      cnt_reg          <= '0;
      domain_reset_reg <= '1;
      timeout_err_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      domain_reset_reg <= domain_reset_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    set_all     = 1'b0;
    release_one = 1'b0;
    timeout_one = 1'b0;
    clear_err   = 1'b0;

    unique case (state_reg)
      HOLD: begin
        set_all = 1'b1;
        if (cnt_reg >= HOLD_LAST) begin
          state_next = RELEASE;
          idx_next   = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      RELEASE: begin
        release_one = 1'b1;
        cnt_next    = '0;
        state_next  = WAIT_ACK;
      end

      WAIT_ACK: begin
        // An ack on the timeout edge takes priority, so no error is flagged.
        if (ack_sel || (cnt_reg >= ACK_LAST)) begin
          timeout_one = !ack_sel;
          cnt_next    = '0;
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      DONE: begin
        if (I_SW_RESET) begin
          state_next = HOLD;
          idx_next   = '0;
          cnt_next   = '0;
          set_all    = 1'b1;
          clear_err  = 1'b1;
        end
      end

      default: begin
        state_next = HOLD;
        idx_next   = '0;
        cnt_next   = '0;
        set_all    = 1'b1;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi = gi + 1) begin : g_domain
      logic sel;
      assign sel = (idx_reg == IDX_W'(gi));
      assign domain_reset_next[gi] = set_all                ? 1'b1 :
                                     (release_one && sel)   ? 1'b0 :
                                     domain_reset_reg[gi];
      assign timeout_err_next[gi]  = clear_err              ? 1'b0 :
                                     (timeout_one && sel)   ? 1'b1 :
                                     timeout_err_reg[gi];
    end
  endgenerate

  assign O_DOMAIN_RESET = domain_reset_reg;
  assign O_TIMEOUT_ERR  = timeout_err_reg;
  assign O_READY        = (state_reg == DONE);
  assign O_BUSY         = (state_reg != DONE);

endmodule
